piano_note_scheduler: RTL

PIANO_NOTE_SCHEDULER -- requirements
Module: piano_note_scheduler

---
 rtl/piano_pkg.sv | 43 ++++
 rtl/tone_div.sv | 47 ++++
 rtl/piano_note_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// piano_pkg
// Shared definitions for the piano note scheduler:
//   NUM_KEYS      number of piano buttons (Do4 .. Do5)
//   NOTE_W        width of a note index
//   half_period_t 17-bit tone divider compare value
//   state_e       scheduler FSM states (IDLE / PLAY / GAP)
//   HALF_PERIOD   per-note half period in clk cycles, minus one
//   lowest_set()  fixed-priority encoder, bit 0 wins
// -----------------------------------------------------------------------------
package piano_pkg;

  localparam int NUM_KEYS = 8;
  localparam int NOTE_W   = $clog2(NUM_KEYS);
  localparam int TONE_W   = 17;

  typedef logic [TONE_W-1:0] half_period_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Square-wave period is 2*(HALF_PERIOD+1) cycles of the 50 MHz clock.
  localparam half_period_t HALF_PERIOD [NUM_KEYS] = '{
    17'd95555, 17'd85130, 17'd75842, 17'd71586,
    17'd63775, 17'd56817, 17'd50619, 17'd47777
  };

  // Index of the lowest set bit; scanning downwards lets the lowest bit
  // overwrite any higher one. Returns 0 for an all-zero vector.
  function automatic logic [NOTE_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    logic [NOTE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = NOTE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tone_div.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tone_div
// Programmable square-wave divider. The counter runs 0..half_period_i and
// wraps; the speaker toggles on the wrap edge.
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   clr_i         clear counter and force speaker low (has priority over en_i)
//   en_i          advance the counter this cycle
//   half_period_i compare value for the wrap
//   speaker_o     square-wave output (registered)
// -----------------------------------------------------------------------------
module tone_div
  import piano_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  half_period_t half_period_i,
  output logic         speaker_o
);

  half_period_t cnt_q;
  logic         spk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else if (en_i) begin
      if (cnt_q == half_period_i) begin
        cnt_q <= '0;
        spk_q <= ~spk_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign speaker_o = spk_q;

endmodule

// File: rtl/piano_note_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// piano_note_scheduler
// Eight-key monophonic piano tone scheduler. Raw keys are synchronized, the
// lowest pressed key wins, and a three-state FSM plays the winning note. Any
// release or change of winner forces GAP_CYCLES of silence before the next
// note (including a re-press of the same note).
// Parameters:
//   GAP_CYCLES   silent cycles between two notes
//   SYNC_STAGES  depth of the key synchronizer
// Ports:
//   clk       50 MHz system clock, rising edge
//   rst_n     asynchronous active-low reset
//   keys      raw buttons, active-high, bit 0 = Do4 .. bit 7 = Do5
//   speaker   square-wave audio output
//   note_idx  note latched for playback
//   playing   high while in PLAY
// -----------------------------------------------------------------------------
module piano_note_scheduler
  import piano_pkg::*;
#(
  parameter int GAP_CYCLES  = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                speaker,
  output logic [NOTE_W-1:0]   note_idx,
  output logic                playing
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Key synchronizer
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] sync_q;
  logic [NUM_KEYS-1:0]                  ks;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= keys;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign ks = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Priority encoder and FSM
  // ---------------------------------------------------------------------------
  logic [NOTE_W-1:0] winner;
  logic              any_key;
  logic              stay_play;

  state_e            state_q;
  logic [NOTE_W-1:0] note_idx_q;
  logic              playing_q;
  logic [GAP_W-1:0]  gap_cnt_q;

  assign winner  = lowest_set(ks);
  assign any_key = |ks;

  // The tone divider only runs while PLAY is being held; every other cycle
  // (IDLE, GAP, and the edge that enters or leaves PLAY) clears it, which
  // silences the speaker and restarts the tone phase at the next note.
  assign stay_play = (state_q == ST_PLAY) && any_key && (winner == note_idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      note_idx_q <= '0;
      playing_q  <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_key) begin
            state_q    <= ST_PLAY;
            note_idx_q <= winner;
            playing_q  <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (!stay_play) begin
            state_q   <= ST_GAP;
            playing_q <= 1'b0;
            gap_cnt_q <= '0;
          end
        end
        ST_GAP: begin
          // Keys are ignored until the last gap cycle, so short glitches or
          // a quick re-press never shorten the silence.
          if (gap_cnt_q == GAP_LAST) begin
            if (any_key) begin
              state_q    <= ST_PLAY;
              note_idx_q <= winner;
              playing_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          playing_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tone divider
  // ---------------------------------------------------------------------------
  tone_div u_tone_div (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (~stay_play),
    .en_i          (stay_play),
    .half_period_i (HALF_PERIOD[note_idx_q]),
    .speaker_o     (speaker)
  );

  assign note_idx = note_idx_q;
  assign playing  = playing_q;

endmodule
